// File: rtl/cordic_cdr_pkg.sv
// Shared widths, CORDIC arctangent table and typedefs for the phase-demodulating
// receiver slice (vectoring CORDIC + clock/data recovery).
package cordic_cdr_pkg;

  // Binary angle: 2^ANGLE_W units per full turn.
  localparam int ANGLE_W  = 8;
  localparam int SAMPLE_W = 5;
  // Internal CORDIC width: sign-extended sample plus guard bits and gain headroom.
  localparam int CORDIC_W = 10;
  localparam int GUARD    = 2;
  localparam int N_ITER   = 6;
  // Wide enough for SAMPLES_PER_BIT deltas of +/-127 without overflow.
  localparam int ACC_W    = 11;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [CORDIC_W-1:0] cordic_t;
  typedef logic        [ANGLE_W-1:0]  angle_t;
  typedef logic signed [ANGLE_W-1:0]  delta_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  // atan(2^-i) in 1/256-turn units.
  localparam angle_t ATAN_LUT [N_ITER] = '{8'd32, 8'd19, 8'd10, 8'd5, 8'd3, 8'd1};
  localparam angle_t ANGLE_PI = 8'd128;

  // CDR control: IDLE means no previous phase has been stored yet.
  typedef enum logic [0:0] {
    CDR_IDLE = 1'b0,
    CDR_RUN  = 1'b1
  } cdr_state_t;

  // One CORDIC pipeline slot.
  typedef struct packed {
    cordic_t x;
    cordic_t y;
    angle_t  ang;
    logic    vld;
  } cordic_stage_t;

  // Sign-extend a sample to the CORDIC width and add the guard bits.
  function automatic cordic_t ext_sample(input sample_t s);
    cordic_t e;
    e = cordic_t'(s);
    return e <<< GUARD;
  endfunction

endpackage

// File: rtl/cordic_cdr_asm_if.sv
// Baseband sample input and recovered-bit output of the receiver slice.
//
// Handshake: iValid is a one-cycle strobe qualifying ibb/qbb in the same cycle;
// there is no ready, the receiver accepts every strobe (up to one per clock).
// bitstream_en is a one-cycle pulse marking a new value on bitstream; the
// consumer has no way to stall it. bitstream holds between pulses.
interface cordic_cdr_asm_if;
  import cordic_cdr_pkg::*;

  sample_t ibb;
  sample_t qbb;
  logic    iValid;
  logic    bitstream;
  logic    bitstream_en;

  // Sampler side: drives samples, observes recovered bits.
  modport master (
    output ibb, qbb, iValid,
    input  bitstream, bitstream_en
  );

  // Receiver side.
  modport slave (
    input  ibb, qbb, iValid,
    output bitstream, bitstream_en
  );

endinterface

// File: rtl/cordic_vec.sv
// Pipelined vectoring CORDIC: rotates (I,Q) onto the +x axis and returns the
// accumulated binary angle. Capture register, one fold stage, ITER iteration
// stages; one sample per clock, angle_valid 7 clocks after the capture edge.
module cordic_vec
  import cordic_cdr_pkg::*;
#(
  parameter int ITER = N_ITER
) (
  input  logic    clk,
  input  logic    reset,
  input  sample_t ibb,
  input  sample_t qbb,
  input  logic    in_valid,
  output angle_t  angle,
  output logic    angle_valid
);

  sample_t       ibb_q;
  sample_t       qbb_q;
  logic          vld_q;
  cordic_stage_t in_stage;
  cordic_stage_t stage     [0:ITER];
  cordic_stage_t iter_next [0:ITER-1];

  // Capture the raw sample and its strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ibb_q <= '0;
      qbb_q <= '0;
      vld_q <= 1'b0;
    end else begin
      ibb_q <= ibb;
      qbb_q <= qbb;
      vld_q <= in_valid;
    end
  end

  // Fold the left half-plane onto the right one so the iterations converge.
  always_comb begin
    cordic_t xe;
    cordic_t ye;
    xe = ext_sample(ibb_q);
    ye = ext_sample(qbb_q);
    in_stage.vld = vld_q;
    if (xe[CORDIC_W-1]) begin
      in_stage.x   = -xe;
      in_stage.y   = -ye;
      in_stage.ang = ANGLE_PI;
    end else begin
      in_stage.x   = xe;
      in_stage.y   = ye;
      in_stage.ang = '0;
    end
  end

  // Micro-rotations: drive y toward zero, accumulating the rotated angle.
  always_comb begin
    for (int i = 0; i < ITER; i++) begin
      cordic_t xc;
      cordic_t yc;
      xc = stage[i].x;
      yc = stage[i].y;
      iter_next[i].vld = stage[i].vld;
      if (!yc[CORDIC_W-1]) begin
        iter_next[i].x   = xc + (yc >>> i);
        iter_next[i].y   = yc - (xc >>> i);
        iter_next[i].ang = stage[i].ang + ATAN_LUT[i];
      end else begin
        iter_next[i].x   = xc - (yc >>> i);
        iter_next[i].y   = yc + (xc >>> i);
        iter_next[i].ang = stage[i].ang - ATAN_LUT[i];
      end
    end
  end

  // Pipeline registers for the fold stage and every iteration stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= ITER; k++) begin
        stage[k] <= '0;
      end
    end else begin
      stage[0] <= in_stage;
      for (int k = 0; k < ITER; k++) begin
        stage[k+1] <= iter_next[k];
      end
    end
  end

  assign angle       = stage[ITER].ang;
  assign angle_valid = stage[ITER].vld;

endmodule

// File: rtl/cordic_cdr_asm.sv
// Phase-demodulating receiver: CORDIC phase extraction followed by clock/data
// recovery that sums modular phase increments over each symbol window and
// slices the sum into one hard bit (positive rotation -> 1).
module cordic_cdr_asm
  import cordic_cdr_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = 5,
  parameter int CORDIC_ITER     = N_ITER
) (
  input  logic              clk,
  input  logic              reset,
  cordic_cdr_asm_if.slave   bus,
  output cdr_state_t        dbg_state
);

  localparam int CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);

  angle_t     phase;
  logic       phase_vld;
  cdr_state_t state_q;
  cdr_state_t state_d;
  logic       store_first;
  logic       take_delta;
  logic       last_in_window;
  angle_t     prev_q;
  acc_t       acc_q;
  logic [CNT_W-1:0] cnt_q;
  delta_t     delta;
  acc_t       acc_sum;
  logic       decision;
  logic       bitstream_q;
  logic       bit_en_q;

  cordic_vec #(
    .ITER (CORDIC_ITER)
  ) u_cordic (
    .clk         (clk),
    .reset       (reset),
    .ibb         (bus.ibb),
    .qbb         (bus.qbb),
    .in_valid    (bus.iValid),
    .angle       (phase),
    .angle_valid (phase_vld)
  );

  // State register: IDLE until the first phase after reset has been stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CDR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the first valid phase arms delta formation for good.
  always_comb begin
    state_d = state_q;
    if (state_q == CDR_IDLE && phase_vld) begin
      state_d = CDR_RUN;
    end
  end

  // Control decode: what the datapath does with this cycle's phase.
  always_comb begin
    store_first    = 1'b0;
    take_delta     = 1'b0;
    last_in_window = 1'b0;
    if (phase_vld) begin
      case (state_q)
        CDR_IDLE: store_first = 1'b1;
        CDR_RUN: begin
          take_delta     = 1'b1;
          last_in_window = (cnt_q == CNT_LAST);
        end
        default: ;
      endcase
    end
  end

  // Modular phase increment, running sum including it, and the bit slicer.
  always_comb begin
    delta    = delta_t'(phase - prev_q);
    acc_sum  = acc_q + acc_t'(delta);
    decision = !acc_sum[ACC_W-1] && (acc_sum != '0);
  end

  // CDR datapath: previous phase, window counter, accumulator, outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bitstream_q <= 1'b0;
      bit_en_q    <= 1'b0;
    end else begin
      bit_en_q <= 1'b0;
      if (store_first) begin
        prev_q <= phase;
        cnt_q  <= CNT_W'(1);
      end
      if (take_delta) begin
        prev_q <= phase;
        if (last_in_window) begin
          acc_q       <= '0;
          cnt_q       <= '0;
          bitstream_q <= decision;
          bit_en_q    <= 1'b1;
        end else begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.bitstream    = bitstream_q;
  assign bus.bitstream_en = bit_en_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_cordic_cdr_asm.sv
// Bench for cordic_cdr_asm: synthesises constant-amplitude I/Q samples whose
// phase steps +/-pi/10 per sample, predicts each recovered bit and the cycle of
// its strobe, and compares them against the receiver outputs.
module tb_cordic_cdr_asm;
  import cordic_cdr_pkg::*;

  localparam real PI   = 3.14159265358979;
  localparam real STEP = PI / 10.0;
  localparam real AMP  = 15.0;

  logic       clk = 1'b0;
  logic       reset;
  cdr_state_t dbg_state;

  cordic_cdr_asm_if bus ();

  cordic_cdr_asm dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulses   = 0;
  int sc       = 0;
  bit first_sample = 1'b1;
  real ph      = 0.0;
  logic last_bit = 1'b0;

  // Scoreboard: expected bit and expected strobe cycle, in order.
  logic [0:0] exp_q[$];
  int         exp_t_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic sample_t quant(input real v);
    return sample_t'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
  endfunction

  task automatic send(input real p, input logic b);
    bus.ibb    = quant(AMP * $cos(p));
    bus.qbb    = quant(AMP * $sin(p));
    bus.iValid = 1'b1;
    sc++;
    if (sc == 5) begin
      exp_q.push_back(b);
      exp_t_q.push_back(cyc + 9);
      sc = 0;
    end
    tick();
    bus.iValid = 1'b0;
  endtask

  // n samples of one bit, one strobe every gap clocks.
  task automatic send_bit(input logic b, input int gap, input int n);
    for (int s = 0; s < n; s++) begin
      if (!first_sample) ph = ph + (b ? STEP : -STEP);
      first_sample = 1'b0;
      send(ph, b);
      repeat (gap - 1) tick();
    end
  endtask

  task automatic restart(input real start_ph);
    reset = 1'b1;
    exp_q.delete();
    exp_t_q.delete();
    sc = 0;
    first_sample = 1'b1;
    ph = start_ph;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    pulses = 0;
  endtask

  task automatic drain();
    repeat (14) tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_bitstream", bus.bitstream, 1'b0);
      chk("rst_bitstream_en", bus.bitstream_en, 1'b0);
      last_bit = 1'b0;
    end else if (bus.bitstream_en) begin
      pulses++;
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", bus.bitstream_en, 1'b0);
      end else begin
        logic [0:0] eb;
        int et;
        eb = exp_q.pop_front();
        et = exp_t_q.pop_front();
        chk("bit", bus.bitstream, eb);
        chk("pulse_cycle", cyc, et);
        last_bit = eb;
      end
    end else begin
      chk("hold", bus.bitstream, last_bit);
      if (exp_t_q.size() > 0 && cyc > exp_t_q[0]) begin
        chk("missing_pulse", bus.bitstream_en, 1'b1);
        void'(exp_q.pop_front());
        void'(exp_t_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [0:0] alt_bits [4];
    logic [0:0] b2b_bits [6];
    alt_bits = '{1'b1, 1'b0, 1'b1, 1'b0};
    b2b_bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    reset      = 1'b1;
    bus.ibb    = '0;
    bus.qbb    = '0;
    bus.iValid = 1'b0;

    // Reset held with toggling inputs.
    repeat (8) begin
      bus.ibb    = sample_t'($urandom_range(0, 31));
      bus.qbb    = sample_t'($urandom_range(0, 31));
      bus.iValid = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_state", dbg_state, CDR_IDLE);
    bus.iValid = 1'b0;
    reset      = 1'b0;
    pulses     = 0;
    repeat (30) tick();
    chk("idle_pulses", pulses, 0);
    chk("idle_state", dbg_state, CDR_IDLE);

    // Single 1-bit from 0.5 rad (first window integrates four deltas).
    restart(0.5);
    send_bit(1'b1, 5, 5);
    drain();
    chk("single_pulses", pulses, 1);
    chk("single_bit", bus.bitstream, 1'b1);
    chk("single_state", dbg_state, CDR_RUN);

    // Alternating 1,0,1,0 at the nominal rate.
    restart(0.0);
    for (int k = 0; k < 4; k++) send_bit(alt_bits[k], 5, 5);
    drain();
    chk("alt_pulses", pulses, 4);
    chk("alt_last_bit", bus.bitstream, 1'b0);

    // Twenty 1-bits starting near 2*pi: repeated 2*pi -> 0 crossings.
    restart(5.8);
    for (int k = 0; k < 20; k++) send_bit(1'b1, 5, 5);
    drain();
    chk("wrap_pulses", pulses, 20);

    // Twenty 0-bits from just above 0: repeated 0 -> 2*pi crossings.
    restart(0.3);
    for (int k = 0; k < 20; k++) send_bit(1'b0, 5, 5);
    drain();
    chk("wrap_neg_pulses", pulses, 20);
    chk("wrap_neg_bit", bus.bitstream, 1'b0);

    // 100 random bits at the nominal rate.
    restart(1.0);
    for (int k = 0; k < 100; k++) send_bit(1'($urandom_range(0, 1)), 5, 5);
    drain();
    chk("rand_pulses", pulses, 100);

    // Back-to-back samples, one per clock.
    restart(2.5);
    for (int k = 0; k < 6; k++) send_bit(b2b_bits[k], 1, 5);
    drain();
    chk("b2b_pulses", pulses, 6);

    // Reset mid-bit: a decided 1, three samples of the next bit, then reset.
    restart(0.7);
    send_bit(1'b1, 5, 5);
    drain();
    chk("pre_rst_bit", bus.bitstream, 1'b1);
    send_bit(1'b0, 5, 3);
    restart(2.0);
    chk("mid_rst_state", dbg_state, CDR_IDLE);
    send_bit(1'b0, 5, 5);
    drain();
    drain();
    chk("mid_rst_pulses", pulses, 1);
    chk("mid_rst_bit", bus.bitstream, 1'b0);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit well above the stimulus length.
  initial begin
    #2000000;
    $display("FAIL timeout: got %0d expected %0d", cyc, 0);
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/cordic_cdr_asm.md
# cordic_cdr_asm

Phase-demodulating receiver slice for an MSK/O-QPSK-style baseband stream. It sits between the baseband I/Q sampler and the bit-level deframer. A pipelined CORDIC (vectoring mode) converts each 5-bit I/Q sample into a phase. A clock/data-recovery stage integrates the sample-to-sample phase increments over each 5-sample symbol and emits one hard bit per symbol, with a strobe.

## Interface
Parameters:
- SAMPLES_PER_BIT, 5: valid samples per data bit.
- CORDIC_ITER, 6: vectoring iterations.
- ANGLE_W, 8: binary-angle width; 2^ANGLE_W = 2π.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ibb  in  5  in-phase sample, signed two's complement; legal range -15..15.
- qbb  in  5  quadrature sample, signed two's complement; legal range -15..15.
- iValid  in  1  one-cycle strobe: ibb/qbb are valid this cycle. There is no backpressure.
- bitstream  out  1  last recovered bit; holds its value until the next decision.
- bitstream_en  out  1  one-cycle pulse when bitstream takes a new value.

## Operation
- Reset: bitstream=0 and bitstream_en=0. Pipeline valid bits, sample counter, accumulator and the have-previous-phase flag are all cleared.
- CORDIC input stage:
  - Sign-extend I and Q to 10 bits and shift left by 2 (guard bits).
  - If x<0, negate x and y and set the angle seed to 128 (π). Otherwise the seed is 0.
- CORDIC iterations i=0..5:
  - If y≥0: x+=y>>>i, y-=x>>>i, angle+=atan_lut[i].
  - Else apply the opposite signs.
  - atan_lut is {32,19,10,5,3,1} in 1/256-turn units.
- Output angle is taken modulo 256. The zero vector gives angle = seed, which is don't-care.
- CDR, on each valid phase:
  - If no previous phase exists, store the phase, set the flag, and do not form a delta.
  - Otherwise delta = (phase − prev) mod 256, interpreted as signed 8-bit. Accumulate delta into an 11-bit signed accumulator and update prev.
- Sample counter:
  - Counts valid phases 0..SAMPLES_PER_BIT−1.
  - Framing starts at the first iValid after reset. The first bit therefore integrates only 4 deltas.
  - On the 5th phase of a window: decision = (acc + delta > 0). Write bitstream, pulse bitstream_en, clear acc and counter.
- Bit polarity: positive phase rotation (counter-clockwise, +π/2 per bit) decodes to 1; negative rotation decodes to 0. An accumulator of exactly zero decodes to 0.
- Wrap-around: crossing 0/2π is handled by the modular delta. Any true |delta| < π decodes correctly.
- No resynchronisation: a lost or extra iValid shifts framing permanently until the next reset.

## Timing
- CORDIC is fully pipelined: 1 input stage + 6 iteration stages, accepts one sample per cycle, latency 7 clocks from the iValid edge to phase-valid.
- CDR adds 1 register stage.
- bitstream and bitstream_en update on the 8th rising edge after the edge that sampled the 5th iValid of a bit.
- bitstream_en is high for exactly one cycle. bitstream is stable from that edge through at least the next decision.
- Nominal input rate is one iValid every 5 clocks; back-to-back iValid (1 per clock) must also work.
- Asserting reset mid-operation aborts all in-flight samples and restarts framing.

## Structure
- Package cordic_cdr_pkg holds the ANGLE_W/width constants, the atan_lut constant array, and the signed sample/angle typedefs.
- Sub-module cordic_vec: the pipelined vectoring CORDIC (ibb, qbb, valid in → angle, valid out).
- Top level: the CDR (prev phase, delta, accumulator, counter, output registers) plus the cordic_vec instance.

## Test plan
- Reset behaviour: hold reset with toggling inputs → bitstream=0, bitstream_en=0. Release, send nothing → no pulses.
- Single bit: start phase 0.5 rad, 5 samples advancing +π/10 (amplitude 15) → one bitstream_en pulse 8 clocks after the 5th iValid, bitstream=1.
- Alternating bits 1,0,1,0 with samples every 5 clocks → pulses every 25 clocks, bits 1,0,1,0. bitstream holds between pulses.
- Phase wrap: rotation repeatedly crossing 2π→0 (e.g. twenty 1-bits) → all 1.
- Random stream of 100 bits, ±π/10 per sample, one iValid per 5 clocks → 100 pulses, 0 mismatches.
- Reset asserted mid-bit after 3 samples, then a fresh 5-sample 0-bit → exactly one pulse, bitstream=0, no stale pulse.
